// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// One single-bit full_adder cell computes one bit per clock, LSB first.
// Operand and result shift registers, a carry flop and a bit counter
// sequence WIDTH steps. A start/ready/done handshake frames each add.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);
    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             V_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    // Upper WIDTH-1 bits of the sum shift register; bit 0 is never needed
    // because the final result is formed from the cell output directly.
    logic [WIDTH-2:0] s_hi_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] s_out_r;
    logic             c_out_r;
    logic             v_out_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] s_next_s;
    logic             msb_step_s;
    logic             ready_s;
    logic             busy_s;
    logic             done_s;

    full_adder u_fa (
        .A     (a_sh_r[0]),
        .B     (b_sh_r[0]),
        .C_in  (carry_r),
        .S     (fa_sum_s),
        .C_out (fa_cout_s)
    );

    // Sum register after this step: new bit enters at the MSB.
    assign s_next_s   = {fa_sum_s, s_hi_r};
    assign msb_step_s = (state_r == ST_ADD) && (count_r == LAST_CNT);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> ADD on start, ADD for WIDTH steps, DONE for one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ADD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (count_r == LAST_CNT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ADD;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, so start never reaches them combinationally.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_ADD:  busy_s  = 1'b1;
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per ADD step, publish on the MSB step.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            s_hi_r  <= {(WIDTH-1){1'b0}};
            carry_r <= 1'b0;
            count_r <= {CW{1'b0}};
            s_out_r <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            v_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r  <= A_in;
                        b_sh_r  <= B_in;
                        carry_r <= C_in;
                        count_r <= {CW{1'b0}};
                    end
                end
                ST_ADD: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    s_hi_r  <= s_next_s[WIDTH-1:1];
                    carry_r <= fa_cout_s;
                    count_r <= count_r + CW'(1);
                    if (msb_step_s) begin
                        s_out_r <= s_next_s;
                        c_out_r <= fa_cout_s;
                        // Overflow: carry into the MSB differs from carry out of it.
                        v_out_r <= carry_r ^ fa_cout_s;
                    end
                end
                default: begin
                    // DONE: results already published; nothing moves.
                end
            endcase
        end
    end

    assign ready = ready_s;
    assign busy  = busy_s;
    assign done  = done_s;
    assign S_out = s_out_r;
    assign C_out = c_out_r;
    assign V_out = v_out_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// A cycle-level behavioural model (remaining-cycle counter plus arithmetic
// sum) is compared against the DUT on every falling edge; directed tests
// add hand-computed literal expectations.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A_in = '0;
    logic [W-1:0] B_in = '0;
    logic         C_in = 1'b0;
    logic         ready, busy, done, C_out, V_out;
    logic [W-1:0] S_out;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .A_in(A_in), .B_in(B_in), .C_in(C_in),
        .ready(ready), .busy(busy), .done(done), .S_out(S_out), .C_out(C_out), .V_out(V_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {V, C, S} of a + b + cin, overflow from operand/result signs.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] sum;
        logic       v;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        return {v, sum};
    endfunction

    // Model: m_rem = cycles until ready again (0 = idle); done is the last busy cycle.
    int           m_rem = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_s = '0;
    logic         m_cin = 1'b0, m_c = 1'b0, m_v = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_rem <= 0; m_s <= '0; m_c <= 1'b0; m_v <= 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem <= W + 1; m_a <= A_in; m_b <= B_in; m_cin <= C_in;
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                {m_v, m_c, m_s} <= ref_add(m_a, m_b, m_cin);
            end
        end
    end

    // Compare DUT to model every cycle.
    always @(negedge CLK) begin
        chk("ready", 32'(ready), 32'(m_rem == 0));
        chk("busy",  32'(busy),  32'(m_rem != 0));
        chk("done",  32'(done),  32'(m_rem == 1));
        chk("S_out", 32'(S_out), 32'(m_s));
        chk("C_out", 32'(C_out), 32'(m_c));
        chk("V_out", 32'(V_out), 32'(m_v));
    end

    // One addition from IDLE; checks done latency and literal results.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic ev, input string nm);
        int  n;
        bit  seen;
        A_in = a; B_in = b; C_in = c; start = 1'b1;
        @(posedge CLK); #2;
        start = 1'b0; A_in = ~a; B_in = 8'h00; C_in = ~c;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge CLK); n++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_latency"}, 32'(n), 32'(W + 1));
        chk({nm, "_S"}, 32'(S_out), 32'(es));
        chk({nm, "_C"}, 32'(C_out), 32'(ec));
        chk({nm, "_V"}, 32'(V_out), 32'(ev));
        @(posedge CLK); #2;
        chk({nm, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        int last_i;
        bit seen;

        // Test 1: reset with start toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #2;
            start = ~start; A_in = 8'h12; B_in = 8'h34;
            @(negedge CLK);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_done",  32'(done),  32'd0);
            chk("rst_S",     32'(S_out), 32'h00);
            chk("rst_CV",    32'({C_out, V_out}), 32'd0);
        end
        @(posedge CLK); #2;
        RST = 1'b1;

        // Test 2 and 3: basic adds, wrap-around and overflow.
        do_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, "t2");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "t3a");
        do_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "t3b");

        // Test 4: start during ADD is ignored; old result held through ADD.
        A_in = 8'h10; B_in = 8'h20; C_in = 1'b0; start = 1'b1;
        @(posedge CLK); #2;
        start = 1'b0;
        dcount = 0; seen = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge CLK);
            if (n == 3) begin start = 1'b1; A_in = 8'hAA; B_in = 8'h55; end
            if (n == 6) start = 1'b0;
            if (done) begin
                dcount++; seen = 1'b1;
                chk("t4_S", 32'(S_out), 32'h30);
            end else if (!seen) begin
                chk("t4_hold", 32'(S_out), 32'h80);
            end
        end
        chk("t4_done_count", 32'(dcount), 32'd1);
        @(posedge CLK); #2;

        // Test 5: reset during ADD discards the operation.
        A_in = 8'h0F; B_in = 8'h01; C_in = 1'b0; start = 1'b1;
        @(posedge CLK); #2;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t5_S_cleared", 32'(S_out), 32'h00);
        chk("t5_ready",     32'(ready), 32'd1);
        @(posedge CLK); #2;
        RST = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done) dcount++;
        end
        chk("t5_no_done", 32'(dcount), 32'd0);
        @(posedge CLK); #2;
        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "t5");

        // Test 6: start held high, operands changing each cycle.
        start = 1'b1;
        dcount = 0; last_i = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #2;
            A_in = 8'($urandom); B_in = 8'($urandom); C_in = 1'($urandom);
            @(negedge CLK);
            if (done) begin
                dcount++;
                if (last_i >= 0) chk("t6_spacing", 32'(i - last_i), 32'd10);
                last_i = i;
            end
        end
        chk("t6_done_count", 32'(dcount), 32'd5);
        start = 1'b0;
        repeat (12) @(posedge CLK);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Performs a WIDTH-bit add using one instance of the existing single-bit full_adder cell (ports A, B, C_in, S, C_out), one bit per clock, LSB first.
- Wraps the cell in operand/result shift registers, a carry flip-flop, a bit counter and a start/done handshake.
- Used where area matters more than latency, e.g. accumulators in slow control paths.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 2.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  request a new addition; sampled only while ready=1.
- A_in  input  WIDTH  operand A, unsigned or two's complement; captured on the accepting edge.
- B_in  input  WIDTH  operand B; captured on the accepting edge.
- C_in  input  1  carry-in; captured on the accepting edge.
- ready  output  1  high in IDLE; block accepts start.
- busy  output  1  high in ADD and DONE.
- done  output  1  one-cycle pulse; result outputs are newly valid.
- S_out  output  WIDTH  sum; holds until overwritten by the next result.
- C_out  output  1  unsigned carry-out of the MSB.
- V_out  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (RST=0, asynchronous, any state): state=IDLE, internal shift regs=0, carry=0, count=0, ready=1, busy=0, done=0, S_out=0, C_out=0, V_out=0.
- IDLE:
  - ready=1.
  - On an edge with start=1: load a_sh<=A_in, b_sh<=B_in, carry<=C_in, count<=0, then go to ADD.
  - On an edge with start=0: remain in IDLE.
- ADD:
  - Full adder inputs are A=a_sh[0], B=b_sh[0], C_in=carry.
  - Each edge:
    - a_sh and b_sh shift right by 1.
    - s_sh <= {fa.S, s_sh[WIDTH-1:1]}.
    - carry <= fa.C_out.
    - count <= count+1.
  - On the edge where count==WIDTH-1 (MSB step):
    - S_out <= {fa.S, s_sh[WIDTH-1:1]}.
    - C_out <= fa.C_out.
    - V_out <= carry ^ fa.C_out.
    - go to DONE.
  - ADD lasts exactly WIDTH cycles.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Let edge 0 be the accepting edge. done is high during the cycle following edge WIDTH.
  - ready returns high after edge WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Output stability:
  - S_out, C_out and V_out change only on the MSB-step edge or on reset.
  - During ADD they hold the previous result.
- Handshake:
  - start is ignored while busy=1, in both ADD and DONE. No queuing, no error flag.
  - A_in, B_in and C_in may change freely after the accepting edge.
  - Holding start high continuously produces back-to-back operations, each re-sampling A_in, B_in and C_in on its accepting edge.
- Wrap-around: the sum is modulo 2^WIDTH; the carry appears only on C_out.
- Reset mid-operation: the partial result is discarded; outputs clear to 0; no done pulse.
- count width: clog2(WIDTH) bits.
- Outputs ready and busy are decoded from state; done is a registered or state decode with no combinational path from start.

Test Plan:
1. Reset: assert RST=0 for 3 cycles with start=1 toggling -> ready=1, busy=0, done=0, S_out=0x00, C_out=0, V_out=0. Release RST -> first start is accepted on the next edge.
2. WIDTH=8, A_in=0x3C, B_in=0x5A, C_in=0. Pulse start -> done high exactly 8 cycles after the accepting edge, with S_out=0x96, C_out=0, V_out=1. ready high on the following cycle.
3. A_in=0xFF, B_in=0x01, C_in=0 -> S_out=0x00, C_out=1, V_out=0. Then A_in=0x7F, B_in=0x00, C_in=1 -> S_out=0x80, C_out=0, V_out=1.
4. Start 0x10+0x20. During ADD cycle 3, raise start with A_in=0xAA, B_in=0x55 -> ignored: done pulses once with S_out=0x30. Check that S_out held its old value through all of ADD.
5. Start 0x0F+0x01, then drive RST=0 during ADD cycle 4 -> immediate IDLE, S_out=0x00, no done pulse. After release, 0x0F+0x01 -> S_out=0x10.
6. Hold start=1 continuously with operands changing every cycle -> done pulses every 10 cycles. Each result matches the operands present on its accepting edge.
